// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan receiver: active-low segment patterns
// for hex digits 0..F, the all-off pattern, and the capture FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG_PAT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_pat_decode.sv
// Combinational decode of one active-low 7-segment pattern into a hex nibble,
// with flags for the all-off pattern and for patterns outside the table.
module seg7_pat_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       err
);

  // Table lookup; blank and unknown patterns both report nibble 0
  always_comb begin
    nibble = 4'h0;
    blank  = 1'b0;
    err    = 1'b0;
    case (pat)
      SEG_PAT[0]:  nibble = 4'h0;
      SEG_PAT[1]:  nibble = 4'h1;
      SEG_PAT[2]:  nibble = 4'h2;
      SEG_PAT[3]:  nibble = 4'h3;
      SEG_PAT[4]:  nibble = 4'h4;
      SEG_PAT[5]:  nibble = 4'h5;
      SEG_PAT[6]:  nibble = 4'h6;
      SEG_PAT[7]:  nibble = 4'h7;
      SEG_PAT[8]:  nibble = 4'h8;
      SEG_PAT[9]:  nibble = 4'h9;
      SEG_PAT[10]: nibble = 4'hA;
      SEG_PAT[11]: nibble = 4'hB;
      SEG_PAT[12]: nibble = 4'hC;
      SEG_PAT[13]: nibble = 4'hD;
      SEG_PAT[14]: nibble = 4'hE;
      SEG_PAT[15]: nibble = 4'hF;
      SEG_BLANK:   blank  = 1'b1;
      default:     err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_rx.sv
// Recovers the digits shown on a multiplexed, active-low 7-segment display:
// synchronizes the lines, debounces each digit dwell and assembles full frames.
module seg7_scan_rx
  import seg7_pkg::*;
#(
  parameter int NDIG   = 8,
  parameter int STABLE = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        seg_i,
  input  logic [NDIG-1:0]   an_i,
  output logic [4*NDIG-1:0] digits_o,
  output logic [NDIG-1:0]   blank_o,
  output logic [NDIG-1:0]   err_o,
  output logic              frame_valid_o,
  input  logic              frame_ready_i,
  output logic              overrun_o
);

  localparam int         IW       = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [7:0] CNT_LAST = 8'(STABLE - 1);

  logic [6:0]        seg_s1_r, seg_s2_r;
  logic [NDIG-1:0]   an_s1_r, an_s2_r;
  logic [IW:0]       low_cnt_s;
  logic [IW-1:0]     sel_idx_s;
  logic              sel_valid_s;
  logic              match_s;

  state_t            state_r, state_n_s;
  logic [7:0]        cnt_r, cnt_n_s;
  logic [IW-1:0]     ref_dig_r, ref_dig_n_s;
  logic [6:0]        ref_seg_r, ref_seg_n_s;
  logic              cap_s;

  logic [3:0]        dec_nib_s;
  logic              dec_blank_s, dec_err_s;

  logic [4*NDIG-1:0] sh_dig_r, sh_dig_n_s;
  logic [NDIG-1:0]   sh_blank_r, sh_blank_n_s;
  logic [NDIG-1:0]   sh_err_r, sh_err_n_s;
  logic [NDIG-1:0]   seen_r, seen_n_s;
  logic              complete_s;

  logic [4*NDIG-1:0] digits_r;
  logic [NDIG-1:0]   blank_r, err_r;
  logic              valid_r, overrun_r;

  // Two-flop synchronizer; idle level is all-ones (nothing lit, nothing enabled)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_r <= '1;
      seg_s2_r <= '1;
      an_s1_r  <= '1;
      an_s2_r  <= '1;
    end else begin
      seg_s1_r <= seg_i;
      seg_s2_r <= seg_s1_r;
      an_s1_r  <= an_i;
      an_s2_r  <= an_s1_r;
    end
  end

  // A digit is selected only when exactly one enable is low
  always_comb begin
    low_cnt_s = '0;
    sel_idx_s = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      low_cnt_s = low_cnt_s + {{IW{1'b0}}, ~an_s2_r[i]};
      sel_idx_s = an_s2_r[i] ? sel_idx_s : IW'(i);
    end
  end

  assign sel_valid_s = (low_cnt_s == {{IW{1'b0}}, 1'b1});
  assign match_s     = sel_valid_s && (sel_idx_s == ref_dig_r) && (seg_s2_r == ref_seg_r);

  // Dwell filter: capture once after STABLE identical samples
  always_comb begin
    state_n_s   = state_r;
    cnt_n_s     = cnt_r;
    ref_dig_n_s = ref_dig_r;
    ref_seg_n_s = ref_seg_r;
    cap_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sel_valid_s) begin
          state_n_s   = ST_SETTLE;
          cnt_n_s     = 8'd1;
          ref_dig_n_s = sel_idx_s;
          ref_seg_n_s = seg_s2_r;
        end else begin
          cnt_n_s = 8'd0;
        end
      end
      ST_SETTLE: begin
        if (!sel_valid_s) begin
          state_n_s = ST_IDLE;
          cnt_n_s   = 8'd0;
        end else if (match_s) begin
          cnt_n_s = cnt_r + 8'd1;
          if (cnt_r == CNT_LAST) begin
            state_n_s = ST_HELD;
            cap_s     = 1'b1;
          end else begin
            state_n_s = ST_SETTLE;
          end
        end else begin
          cnt_n_s     = 8'd1;
          ref_dig_n_s = sel_idx_s;
          ref_seg_n_s = seg_s2_r;
        end
      end
      ST_HELD: begin
        if (!sel_valid_s) begin
          state_n_s = ST_IDLE;
          cnt_n_s   = 8'd0;
        end else if (!match_s) begin
          state_n_s   = ST_SETTLE;
          cnt_n_s     = 8'd1;
          ref_dig_n_s = sel_idx_s;
          ref_seg_n_s = seg_s2_r;
        end else begin
          state_n_s = ST_HELD;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
        cnt_n_s   = 8'd0;
      end
    endcase
  end

  // Filter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 8'd0;
      ref_dig_r <= '0;
      ref_seg_r <= '1;
    end else begin
      state_r   <= state_n_s;
      cnt_r     <= cnt_n_s;
      ref_dig_r <= ref_dig_n_s;
      ref_seg_r <= ref_seg_n_s;
    end
  end

  // On capture the sample equals the reference, so the reference is decoded
  seg7_pat_decode u_dec (
    .pat    (ref_seg_r),
    .nibble (dec_nib_s),
    .blank  (dec_blank_s),
    .err    (dec_err_s)
  );

  // Shadow update; a frame completes in the cycle its last seen bit would be set
  always_comb begin
    sh_dig_n_s   = sh_dig_r;
    sh_blank_n_s = sh_blank_r;
    sh_err_n_s   = sh_err_r;
    seen_n_s     = seen_r;
    for (int k = 0; k < NDIG; k++) begin
      sh_dig_n_s[4*k +: 4] = (cap_s && (ref_dig_r == IW'(k))) ? dec_nib_s   : sh_dig_r[4*k +: 4];
      sh_blank_n_s[k]      = (cap_s && (ref_dig_r == IW'(k))) ? dec_blank_s : sh_blank_r[k];
      sh_err_n_s[k]        = (cap_s && (ref_dig_r == IW'(k))) ? dec_err_s   : sh_err_r[k];
      seen_n_s[k]          = (cap_s && (ref_dig_r == IW'(k))) ? 1'b1        : seen_r[k];
    end
    complete_s = &seen_n_s;
  end

  // Shadow registers and seen bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_dig_r   <= '0;
      sh_blank_r <= '0;
      sh_err_r   <= '0;
      seen_r     <= '0;
    end else begin
      sh_dig_r   <= sh_dig_n_s;
      sh_blank_r <= sh_blank_n_s;
      sh_err_r   <= sh_err_n_s;
      seen_r     <= complete_s ? '0 : seen_n_s;
    end
  end

  // Output frame: load when empty or being accepted, otherwise drop and flag overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_r  <= '0;
      blank_r   <= '0;
      err_r     <= '0;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= 1'b0;
      if (complete_s) begin
        if (!valid_r || frame_ready_i) begin
          digits_r <= sh_dig_n_s;
          blank_r  <= sh_blank_n_s;
          err_r    <= sh_err_n_s;
          valid_r  <= 1'b1;
        end else begin
          overrun_r <= 1'b1;
        end
      end else if (valid_r && frame_ready_i) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign digits_o      = digits_r;
  assign blank_o       = blank_r;
  assign err_o         = err_r;
  assign frame_valid_o = valid_r;
  assign overrun_o     = overrun_r;

endmodule

// File: tb/tb_seg7_scan_rx.sv
// Directed bench for seg7_scan_rx: drives multiplexed scans and checks the
// delivered frames against a queue of expected frames.
module tb_seg7_scan_rx;

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  b;
    logic [7:0]  e;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_i;
  logic [7:0]  an_i;
  logic [31:0] digits_o;
  logic [7:0]  blank_o;
  logic [7:0]  err_o;
  logic        frame_valid_o;
  logic        frame_ready_i;
  logic        overrun_o;

  int checks = 0;
  int failures = 0;
  int ovr_cnt = 0;
  int ovr_base;
  logic        mid_valid;
  logic [31:0] mid_digits;
  frame_t      exp_q [$];

  logic [6:0] hexpat [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  seg7_scan_rx #(.NDIG(8), .STABLE(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .seg_i         (seg_i),
    .an_i          (an_i),
    .digits_o      (digits_o),
    .blank_o       (blank_o),
    .err_o         (err_o),
    .frame_valid_o (frame_valid_o),
    .frame_ready_i (frame_ready_i),
    .overrun_o     (overrun_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (overrun_o === 1'b1) ovr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    an_i  = 8'hFF;
    seg_i = 7'h7F;
    repeat (n) @(negedge clk);
  endtask

  // Drive digit k with pattern pat for n cycles; optionally pulse ready on cycle rdy_at
  task automatic show(input int k, input logic [6:0] pat, input int n, input int rdy_at);
    an_i  = ~(8'h01 << k);
    seg_i = pat;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      frame_ready_i = (c + 1 == rdy_at);
      if (rdy_at > 0 && c + 1 == rdy_at + 1) begin
        mid_valid  = frame_valid_o;
        mid_digits = digits_o;
      end
    end
  endtask

  task automatic scan_hex(input logic [31:0] nibs, input bit push, input int rdy_at);
    frame_t f;
    if (push) begin
      f.d = nibs;
      f.b = 8'h00;
      f.e = 8'h00;
      exp_q.push_back(f);
    end
    for (int k = 0; k < 8; k++) begin
      show(k, hexpat[nibs[4*k +: 4]], 20, (k == 7) ? rdy_at : 0);
    end
    idle(4);
  endtask

  task automatic wait_valid(input int bound);
    int n = 0;
    while (frame_valid_o !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("valid_wait", {31'd0, frame_valid_o}, 32'd1);
  endtask

  task automatic check_frame(input string tag);
    frame_t f;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=frame expected=none_queued", tag);
    end else begin
      f = exp_q.pop_front();
      chk({tag, "_digits"}, digits_o, f.d);
      chk({tag, "_blank"}, {24'd0, blank_o}, {24'd0, f.b});
      chk({tag, "_err"}, {24'd0, err_o}, {24'd0, f.e});
    end
  endtask

  task automatic accept();
    frame_ready_i = 1'b1;
    @(negedge clk);
    frame_ready_i = 1'b0;
    chk("valid_cleared", {31'd0, frame_valid_o}, 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_digits"}, digits_o, 32'd0);
    chk({tag, "_blank"}, {24'd0, blank_o}, 32'd0);
    chk({tag, "_err"}, {24'd0, err_o}, 32'd0);
    chk({tag, "_valid"}, {31'd0, frame_valid_o}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, overrun_o}, 32'd0);
  endtask

  initial begin
    frame_t f;
    rst_n = 1'b0;
    frame_ready_i = 1'b0;
    an_i = 8'hFF;
    seg_i = 7'h7F;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    idle(4);

    // Plain scan: digit k shows hex k
    scan_hex(32'h76543210, 1'b1, 0);
    wait_valid(50);
    check_frame("scan_hex");
    chk("no_overrun_1", 32'(ovr_cnt), 32'd0);
    accept();

    // Glitch on digit 3, blank digit 5, illegal pattern on digit 6
    f.d = 32'h70043210;
    f.b = 8'h20;
    f.e = 8'h40;
    exp_q.push_back(f);
    show(0, hexpat[0], 20, 0);
    show(1, hexpat[1], 20, 0);
    show(2, hexpat[2], 20, 0);
    show(3, 7'h00, 10, 0);
    show(3, 7'h30, 20, 0);
    show(4, hexpat[4], 20, 0);
    show(5, 7'h7F, 20, 0);
    show(6, 7'h55, 20, 0);
    show(7, hexpat[7], 20, 0);
    idle(4);
    wait_valid(50);
    check_frame("glitch_blank_err");
    accept();

    // Two scans with no ready: first frame held, second dropped with one overrun
    ovr_base = ovr_cnt;
    scan_hex(32'h3210FEDC, 1'b1, 0);
    wait_valid(50);
    scan_hex(32'hFEDCBA98, 1'b0, 0);
    chk("overrun_once", 32'(ovr_cnt - ovr_base), 32'd1);
    check_frame("held_frame");
    accept();

    // Ready coincides with completion of the next frame: no gap, no overrun
    ovr_base = ovr_cnt;
    scan_hex(32'h13579BDF, 1'b1, 0);
    wait_valid(50);
    check_frame("frame_a");
    scan_hex(32'h02468ACE, 1'b1, 17);
    chk("handover_valid", {31'd0, mid_valid}, 32'd1);
    chk("handover_digits", mid_digits, 32'h02468ACE);
    check_frame("frame_b");
    chk("handover_no_overrun", 32'(ovr_cnt - ovr_base), 32'd0);
    accept();

    // Multiple enables low, then reset in the middle of a dwell
    ovr_base = ovr_cnt;
    an_i = 8'hF0;
    seg_i = hexpat[1];
    repeat (40) @(negedge clk);
    chk("multi_sel_no_frame", {31'd0, frame_valid_o}, 32'd0);
    show(2, hexpat[2], 8, 0);
    rst_n = 1'b0;
    an_i = 8'hFF;
    seg_i = 7'h7F;
    repeat (3) @(negedge clk);
    check_zero("mid_reset");
    rst_n = 1'b1;
    idle(40);
    check_zero("post_reset");
    chk("post_reset_no_overrun", 32'(ovr_cnt - ovr_base), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
